// File: rtl/memory_bus_responder_if.sv
// CPU request/response, decoder select and target strobe/ack bundle for the memory responder.
// The slave modport is the responder's view; the master modport is the CPU, decoder and target side.
interface memory_bus_responder_if #(
  parameter int DATA_W = 32
);
  // CPU request channel
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [31:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;

  // Region decoder selects
  logic                  dec_bram;
  logic                  dec_sram;
  logic                  dec_flash;
  logic                  dec_periph;
  logic                  dec_error;

  // Target side, bit order {periph,flash,sram,bram}
  logic [3:0]            tgt_req;
  logic                  tgt_write;
  logic [31:0]           tgt_addr;
  logic [DATA_W-1:0]     tgt_wdata;
  logic [3:0]            tgt_ack;
  logic [4*DATA_W-1:0]   tgt_rdata;

  // CPU response channel
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_error;
  logic [1:0]            resp_code;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  dec_bram, dec_sram, dec_flash, dec_periph, dec_error,
    input  tgt_ack, tgt_rdata,
    input  resp_ready,
    output req_ready,
    output tgt_req, tgt_write, tgt_addr, tgt_wdata,
    output resp_valid, resp_rdata, resp_error, resp_code
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output dec_bram, dec_sram, dec_flash, dec_periph, dec_error,
    output tgt_ack, tgt_rdata,
    output resp_ready,
    input  req_ready,
    input  tgt_req, tgt_write, tgt_addr, tgt_wdata,
    input  resp_valid, resp_rdata, resp_error, resp_code
  );
endinterface

// File: rtl/memory_bus_responder.sv
// Single-outstanding responder: routes a decoded CPU access to one target and returns data/status.
// Latency: decode error 1 cycle, ack in first WAIT cycle 2 cycles; a held response blocks new requests.
module memory_bus_responder #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  memory_bus_responder_if.slave  bus
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] CODE_OK  = 2'b00;
  localparam logic [1:0] CODE_DEC = 2'b01;
  localparam logic [1:0] CODE_TMO = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              error;
    logic [1:0]        code;
  } resp_t;

  typedef struct packed {
    logic [3:0]        sel;
    logic              write;
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
  } tgt_cmd_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q;
  tgt_cmd_t          cmd_q;
  logic              resp_valid_q;
  resp_t             resp_q;

  logic [3:0]        dec_sel;
  logic              dec_ok;
  logic              sel_ack;
  logic [DATA_W-1:0] ack_rdata;

  assign dec_sel = {bus.dec_periph, bus.dec_flash, bus.dec_sram, bus.dec_bram};
  assign dec_ok  = !bus.dec_error && $onehot(dec_sel);

  // cmd_q.sel is only non-zero in WAIT, so acks seen elsewhere fall through here.
  assign sel_ack = |(bus.tgt_ack & cmd_q.sel);

  always_comb begin
    ack_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_q.sel[i]) begin
        ack_rdata = ack_rdata | bus.tgt_rdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      cmd_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            if (dec_ok) begin
              cmd_q.sel   <= dec_sel;
              cmd_q.write <= bus.req_write;
              cmd_q.addr  <= bus.req_addr;
              cmd_q.wdata <= bus.req_wdata;
              cnt_q       <= '0;
              state_q     <= S_WAIT;
            end else begin
              resp_valid_q <= 1'b1;
              resp_q.rdata <= '0;
              resp_q.error <= 1'b1;
              resp_q.code  <= CODE_DEC;
              state_q      <= S_RESP;
            end
          end
        end

        S_WAIT: begin
          // An ack in the last counted cycle still completes the access normally.
          if (sel_ack) begin
            cmd_q.sel    <= 4'b0000;
            resp_valid_q <= 1'b1;
            resp_q.rdata <= cmd_q.write ? '0 : ack_rdata;
            resp_q.error <= 1'b0;
            resp_q.code  <= CODE_OK;
            state_q      <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            cmd_q.sel    <= 4'b0000;
            resp_valid_q <= 1'b1;
            resp_q.rdata <= '0;
            resp_q.error <= 1'b1;
            resp_q.code  <= CODE_TMO;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            req_ready_q  <= 1'b1;
            state_q      <= S_IDLE;
          end
        end

        default: begin
          cmd_q.sel    <= 4'b0000;
          resp_valid_q <= 1'b0;
          resp_q       <= '0;
          req_ready_q  <= 1'b1;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.tgt_req    = cmd_q.sel;
  assign bus.tgt_write  = cmd_q.write;
  assign bus.tgt_addr   = cmd_q.addr;
  assign bus.tgt_wdata  = cmd_q.wdata;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_q.rdata;
  assign bus.resp_error = resp_q.error;
  assign bus.resp_code  = resp_q.code;

endmodule

// File: tb/tb_memory_bus_responder.sv
// Directed bench for memory_bus_responder; responses are checked against a queue of expected results.
module tb_memory_bus_responder;

  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  memory_bus_responder_if #(.DATA_W(DATA_W)) bus ();

  memory_bus_responder #(
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic [1:0]  code;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] rdata, input logic [1:0] code);
    exp_t e;
    e.rdata = rdata;
    e.error = (code != 2'b00);
    e.code  = code;
    sb_q.push_back(e);
  endtask

  task automatic set_dec(input logic [4:0] dec);
    {bus.dec_error, bus.dec_periph, bus.dec_flash, bus.dec_sram, bus.dec_bram} = dec;
  endtask

  // dec = {error, periph, flash, sram, bram}; returns one cycle after the accept edge
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [4:0] dec);
    check("req_ready_before_accept", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    set_dec(dec);
    tick();
    bus.req_valid = 1'b0;
    set_dec(5'b00000);
  endtask

  // Response monitor: a handshake happens on the coming edge
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (rst === 1'b0 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
      got = {bus.resp_rdata, bus.resp_error, bus.resp_code};
      if (sb_q.size() == 0) begin
        check("resp_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check("resp_payload", 64'(got), 64'(e));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [4:0] bad_dec [3];
    bad_dec[0] = 5'b10000;
    bad_dec[1] = 5'b00110;
    bad_dec[2] = 5'b00000;

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    set_dec(5'b00000);
    bus.tgt_ack    = 4'b0000;
    bus.tgt_rdata  = '0;
    bus.resp_ready = 1'b1;
    tick(); tick(); tick();

    // Reset state
    check("rst_req_ready",  bus.req_ready,  1'b1);
    check("rst_tgt_req",    bus.tgt_req,    4'b0000);
    check("rst_resp_valid", bus.resp_valid, 1'b0);
    check("rst_resp_code",  bus.resp_code,  2'b00);
    check("rst_tgt_addr",   bus.tgt_addr,   32'h0);
    rst = 1'b0;
    tick();

    // 1: bram read, ack in first WAIT cycle
    issue(1'b0, 32'h0000_0010, 32'h0, 5'b00001);
    check("t1_tgt_req",    bus.tgt_req,    4'b0001);
    check("t1_tgt_addr",   bus.tgt_addr,   32'h0000_0010);
    check("t1_tgt_write",  bus.tgt_write,  1'b0);
    check("t1_resp_early", bus.resp_valid, 1'b0);
    check("t1_req_ready",  bus.req_ready,  1'b0);
    bus.tgt_rdata[0 +: 32] = 32'hDEAD_BEEF;
    bus.tgt_ack = 4'b0001;
    push_exp(32'hDEAD_BEEF, 2'b00);
    tick();
    bus.tgt_ack = 4'b0000;
    check("t1_resp_valid", bus.resp_valid, 1'b1);
    check("t1_tgt_req_drop", bus.tgt_req,  4'b0000);
    check("t1_rdata",      bus.resp_rdata, 32'hDEAD_BEEF);
    tick();
    check("t1_idle_resp_valid", bus.resp_valid, 1'b0);
    check("t1_idle_req_ready",  bus.req_ready,  1'b1);
    check("t1_idle_rdata",      bus.resp_rdata, 32'h0);

    // 2: periph write, stray bram ack ignored, periph ack in 4th WAIT cycle
    bus.tgt_rdata[3*32 +: 32] = 32'hCAFE_F00D;
    issue(1'b1, 32'h0003_0004, 32'h0000_0055, 5'b01000);
    check("t2_tgt_wdata", bus.tgt_wdata, 32'h55);
    check("t2_tgt_write", bus.tgt_write, 1'b1);
    check("t2_tgt_addr",  bus.tgt_addr,  32'h0003_0004);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tgt_req !== 4'b1000 || bus.resp_valid !== 1'b0) bad++;
      bus.tgt_ack = (i == 1) ? 4'b0001 : (i == 3) ? 4'b1000 : 4'b0000;
      if (i == 3) push_exp(32'h0, 2'b00);
      tick();
    end
    bus.tgt_ack = 4'b0000;
    check("t2_req_held_4", bad, 0);
    check("t2_resp_valid", bus.resp_valid, 1'b1);
    check("t2_tgt_req_drop", bus.tgt_req, 4'b0000);
    tick();

    // 3: decode errors (dec_error, two selects, no select)
    for (int k = 0; k < 3; k++) begin
      push_exp(32'h0, 2'b01);
      issue(1'b0, 32'h0005_0000, 32'h0, bad_dec[k]);
      check("t3_resp_valid", bus.resp_valid, 1'b1);
      check("t3_tgt_req",    bus.tgt_req,    4'b0000);
      check("t3_code",       bus.resp_code,  2'b01);
      tick();
    end
    push_exp(32'h0, 2'b01);
    issue(1'b0, 32'h0005_0000, 32'h0, 5'b10001);
    check("t3_err_with_sel_tgt_req", bus.tgt_req, 4'b0000);
    tick();

    // 4a: sram read with no ack times out, late ack ignored
    push_exp(32'h0, 2'b10);
    issue(1'b0, 32'h2000_0100, 32'h0, 5'b00010);
    bad = 0;
    for (int c = 1; c <= TIMEOUT_CYC; c++) begin
      if (bus.tgt_req !== 4'b0010 || bus.resp_valid !== 1'b0) bad++;
      tick();
    end
    check("t4_wait_hold",   bad, 0);
    check("t4_resp_valid",  bus.resp_valid, 1'b1);
    check("t4_code",        bus.resp_code,  2'b10);
    check("t4_tgt_req_drop", bus.tgt_req,   4'b0000);
    bus.tgt_rdata[1*32 +: 32] = 32'h0000_0077;
    bus.tgt_ack = 4'b0010;
    tick();
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.tgt_req !== 4'b0000) bad++;
      tick();
    end
    bus.tgt_ack = 4'b0000;
    check("t4_late_ack_ignored", bad, 0);

    // 4b: ack in the final counted cycle wins over timeout
    issue(1'b0, 32'h2000_0104, 32'h0, 5'b00010);
    for (int c = 1; c < TIMEOUT_CYC; c++) tick();
    check("t4b_no_resp_yet", bus.resp_valid, 1'b0);
    bus.tgt_ack = 4'b0010;
    push_exp(32'h0000_0077, 2'b00);
    tick();
    bus.tgt_ack = 4'b0000;
    check("t4b_resp_valid", bus.resp_valid, 1'b1);
    check("t4b_code",       bus.resp_code,  2'b00);
    tick();

    // 5: response held under backpressure, back-to-back request after one bubble
    bus.resp_ready = 1'b0;
    issue(1'b0, 32'h0000_0040, 32'h0, 5'b00001);
    bus.tgt_rdata[0 +: 32] = 32'h1234_5678;
    bus.tgt_ack = 4'b0001;
    push_exp(32'h1234_5678, 2'b00);
    tick();
    bus.tgt_ack   = 4'b0000;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 32'h0000_0044;
    set_dec(5'b00001);
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h1234_5678 ||
          bus.resp_code !== 2'b00 || bus.req_ready !== 1'b0 || bus.tgt_req !== 4'b0000) bad++;
      tick();
    end
    check("t5_resp_stable", bad, 0);
    bus.resp_ready = 1'b1;
    tick();
    check("t5_bubble_req_ready", bus.req_ready,  1'b1);
    check("t5_bubble_tgt_req",   bus.tgt_req,    4'b0000);
    check("t5_bubble_resp",      bus.resp_valid, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    set_dec(5'b00000);
    check("t5_second_tgt_req",  bus.tgt_req,  4'b0001);
    check("t5_second_tgt_addr", bus.tgt_addr, 32'h0000_0044);
    bus.tgt_rdata[0 +: 32] = 32'hA5A5_0044;
    bus.tgt_ack = 4'b0001;
    push_exp(32'hA5A5_0044, 2'b00);
    tick();
    bus.tgt_ack = 4'b0000;
    tick();

    // 6: reset during WAIT drops the access
    issue(1'b0, 32'h2000_0200, 32'h0, 5'b00010);
    tick();
    rst = 1'b1;
    tick();
    check("t6_req_ready",  bus.req_ready,  1'b1);
    check("t6_tgt_req",    bus.tgt_req,    4'b0000);
    check("t6_resp_valid", bus.resp_valid, 1'b0);
    rst = 1'b0;
    bus.tgt_ack = 4'b0010;
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || bus.tgt_req !== 4'b0000) bad++;
    end
    bus.tgt_ack = 4'b0000;
    check("t6_post_rst_ack_ignored", bad, 0);

    // Flash read after reset
    issue(1'b0, 32'h1000_0008, 32'h0, 5'b00100);
    check("t6_flash_tgt_req", bus.tgt_req, 4'b0100);
    bus.tgt_rdata[2*32 +: 32] = 32'h0F0F_1234;
    bus.tgt_ack = 4'b0100;
    push_exp(32'h0F0F_1234, 2'b00);
    tick();
    bus.tgt_ack = 4'b0000;
    tick();
    tick();

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
